// File: rtl/ghost_move_scheduler.sv
`default_nettype none
// ============================================================================
// ghost_move_scheduler - steps four ghosts once per frame over a shared
// maze-wall lookup port. Optional macro GHOST_WRAP_EN enables the x tunnel.
// Revision: 1.0
// ============================================================================
module ghost_move_scheduler #(
   parameter int STEP    = 1,
   parameter int START_X = 144,
   parameter int START_Y = 112,
   parameter int X_MAX   = 319,
   parameter int Y_MAX   = 239
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       enable,
   output logic       wall_req,
   output logic [8:0] wall_x,
   output logic [8:0] wall_y,
   input  logic       wall_ack,
   input  logic       wall_hit,
   output logic [8:0] x_red,
   output logic [8:0] y_red,
   output logic [8:0] x_blue,
   output logic [8:0] y_blue,
   output logic [8:0] x_yellow,
   output logic [8:0] y_yellow,
   output logic [8:0] x_pink,
   output logic [8:0] y_pink,
   output logic       busy,
   output logic       frame_miss
);

   localparam logic [9:0] STEP_W  = 10'(STEP);
   localparam logic [9:0] X_MAX_W = 10'(X_MAX);
   localparam logic [9:0] Y_MAX_W = 10'(Y_MAX);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CHECK  = 3'd1,
      QUERY  = 3'd2,
      ROTATE = 3'd3,
      MOVE   = 3'd4,
      NEXT   = 3'd5
   } state_t;

   state_t     state;
   logic [8:0] pos_x [4];
   logic [8:0] pos_y [4];
   logic [1:0] dir   [4];
   logic [1:0] start_dir;
   logic [1:0] idx;
   logic [1:0] tries;

   logic [9:0] cand_x;
   logic [9:0] cand_y;
   logic       cand_ok;

   // Candidate is built in 10 bits so a step below zero shows up as a large value.
   always_comb begin
      cand_x = {1'b0, pos_x[idx]};
      cand_y = {1'b0, pos_y[idx]};
      case (dir[idx])
         2'd0:    cand_x = cand_x + STEP_W;
         2'd1:    cand_y = cand_y + STEP_W;
         2'd2:    cand_x = cand_x - STEP_W;
         default: cand_y = cand_y - STEP_W;
      endcase
`ifdef GHOST_WRAP_EN
      if (dir[idx] == 2'd2 && {1'b0, pos_x[idx]} < STEP_W)
         cand_x = X_MAX_W - STEP_W + 10'd1 + {1'b0, pos_x[idx]};
      else if (dir[idx] == 2'd0 && cand_x > X_MAX_W)
         cand_x = cand_x - X_MAX_W - 10'd1;
`endif
      cand_ok = (cand_x <= X_MAX_W) && (cand_y <= Y_MAX_W);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         wall_req   <= 1'b0;
         wall_x     <= '0;
         wall_y     <= '0;
         busy       <= 1'b0;
         frame_miss <= 1'b0;
         idx        <= '0;
         tries      <= '0;
         start_dir  <= '0;
         for (int i = 0; i < 4; i++) begin
            pos_x[i] <= 9'(START_X + 16 * i);
            pos_y[i] <= 9'(START_Y);
            dir[i]   <= 2'(i);
         end
      end else begin
         frame_miss <= frame_tick && busy;
         case (state)
            IDLE: begin
               if (frame_tick && enable) begin
                  state     <= CHECK;
                  idx       <= '0;
                  tries     <= '0;
                  busy      <= 1'b1;
                  start_dir <= dir[0];
               end
            end
            CHECK: begin
               if (!cand_ok) begin
                  state <= ROTATE;
               end else begin
                  wall_x   <= cand_x[8:0];
                  wall_y   <= cand_y[8:0];
                  wall_req <= 1'b1;
                  state    <= QUERY;
               end
            end
            QUERY: begin
               if (wall_ack) begin
                  wall_req <= 1'b0;
                  state    <= wall_hit ? ROTATE : MOVE;
               end
            end
            ROTATE: begin
               wall_req <= 1'b0;
               // A ghost boxed in on all four sides keeps the heading it started with.
               if (tries == 2'd3) begin
                  dir[idx] <= start_dir;
                  state    <= NEXT;
               end else begin
                  dir[idx] <= dir[idx] + 2'd1;
                  tries    <= tries + 2'd1;
                  state    <= CHECK;
               end
            end
            MOVE: begin
               pos_x[idx] <= wall_x;
               pos_y[idx] <= wall_y;
               state      <= NEXT;
            end
            NEXT: begin
               if (idx == 2'd3) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  idx       <= idx + 2'd1;
                  tries     <= '0;
                  start_dir <= dir[idx + 2'd1];
                  state     <= CHECK;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign x_red    = pos_x[0];
   assign y_red    = pos_y[0];
   assign x_blue   = pos_x[1];
   assign y_blue   = pos_y[1];
   assign x_yellow = pos_x[2];
   assign y_yellow = pos_y[2];
   assign x_pink   = pos_x[3];
   assign y_pink   = pos_y[3];

endmodule
`default_nettype wire
